// File: rtl/serial_add_pkg.sv
// Shared types for the serial adder arbiter: FSM states, default operand width
// and the bit-counter sizing helper.
package serial_add_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Counter only needs to reach WIDTH-1; keep at least one bit for WIDTH=2.
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_add_core.sv
// Bit-serial adder datapath: one sum bit per shift edge, LSB first.
// sum_nxt/cout_nxt expose the value the registers take on the current shift edge.
module serial_add_core
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] sum_nxt,
  output logic             cout_nxt,
  output logic             last
);

  localparam int CW = cnt_width(WIDTH);

  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sum_bit, carry_bit;

  always_comb begin
    sum_bit   = a_q[0] ^ b_q[0] ^ carry_q;
    carry_bit = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    carry_d   = carry_q;
    cnt_d     = cnt_q;
    if (load) begin
      a_d     = a_in;
      b_d     = b_in;
      carry_d = 1'b0;
      cnt_d   = '0;
    end else if (shift) begin
      a_d     = a_q >> 1;
      b_d     = b_q >> 1;
      sum_d   = {sum_bit, sum_q[WIDTH-1:1]};
      carry_d = carry_bit;
      cnt_d   = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sum_nxt  = {sum_bit, sum_q[WIDTH-1:1]};
  assign cout_nxt = carry_bit;
  assign last     = shift && (cnt_q == CW'(WIDTH - 1));

endmodule

// File: rtl/serial_add_arbiter.sv
// Two requesters share one bit-serial adder; WIDTH+2 cycles per result.
// Requests only accepted in IDLE; the response holds in DONE until resp_ready.
module serial_add_arbiter
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_sum,
  output logic             resp_cout,
  output logic             busy
);

  state_e           state_q, state_d;
  logic             ptr_q, ptr_d;
  logic             id_q, id_d;
  logic             resp_valid_q, resp_valid_d;
  logic             resp_id_q, resp_id_d;
  logic [WIDTH-1:0] resp_sum_q, resp_sum_d;
  logic             resp_cout_q, resp_cout_d;

  logic             idle, gnt0, gnt1, accept, last, cout_nxt;
  logic [WIDTH-1:0] sum_nxt;

  // ptr_q names the requester that wins a tie; it flips to the other side after each service.
  assign idle   = (state_q == ST_IDLE);
  assign gnt0   = idle && req0_valid && (!req1_valid || !ptr_q);
  assign gnt1   = idle && req1_valid && !gnt0;
  assign accept = gnt0 || gnt1;

  serial_add_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .shift    (state_q == ST_SHIFT),
    .a_in     (gnt1 ? req1_a : req0_a),
    .b_in     (gnt1 ? req1_b : req0_b),
    .sum_nxt  (sum_nxt),
    .cout_nxt (cout_nxt),
    .last     (last)
  );

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    id_d         = id_q;
    resp_valid_d = resp_valid_q;
    resp_id_d    = resp_id_q;
    resp_sum_d   = resp_sum_q;
    resp_cout_d  = resp_cout_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_SHIFT;
          id_d    = gnt1;
        end
      end
      ST_SHIFT: begin
        if (last) begin
          state_d      = ST_DONE;
          resp_valid_d = 1'b1;
          resp_sum_d   = sum_nxt;
          resp_cout_d  = cout_nxt;
          resp_id_d    = id_q;
        end
      end
      ST_DONE: begin
        if (resp_ready) begin
          state_d      = ST_IDLE;
          resp_valid_d = 1'b0;
          ptr_d        = !resp_id_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      ptr_q        <= 1'b0;
      id_q         <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= 1'b0;
      resp_sum_q   <= '0;
      resp_cout_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      id_q         <= id_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_sum_q   <= resp_sum_d;
      resp_cout_q  <= resp_cout_d;
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_sum   = resp_sum_q;
  assign resp_cout  = resp_cout_q;
  assign busy       = !idle;

endmodule

// File: tb/tb_serial_add_arbiter.sv
// Scoreboard bench for serial_add_arbiter: a cycle model predicts grants and
// result timing; expected results queue at accept and are compared in DONE.
module tb_serial_add_arbiter;

  localparam int WIDTH = 8;

  typedef struct {
    logic             id;
    logic [WIDTH-1:0] sum;
    logic             cout;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             req0_valid, req0_ready, req1_valid, req1_ready;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
  logic             resp_valid, resp_ready, resp_id, resp_cout, busy;
  logic [WIDTH-1:0] resp_sum;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  exp_t             sb[$];
  logic [WIDTH-1:0] q0a[$], q0b[$], q1a[$], q1b[$];
  int               acc_cyc[$];
  logic             ids_seen[$];

  logic             m_busy = 1'b0;
  logic             m_ptr  = 1'b0;
  int               m_wait = 0;
  logic [WIDTH-1:0] last_sum  = '0;
  logic             last_cout = 1'b0;
  logic             last_id   = 1'b0;

  always #5 clk = ~clk;

  serial_add_arbiter #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_sum   (resp_sum),
    .resp_cout  (resp_cout),
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Cycle model, evaluated mid-cycle while inputs are stable.
  always @(negedge clk) begin
    logic g0, g1;
    logic [WIDTH:0] full;
    exp_t e;
    cyc++;
    chk("rdy_excl", req0_ready & req1_ready, 0);
    if (rst) begin
      m_busy = 1'b0; m_ptr = 1'b0; m_wait = 0;
      sb.delete();
      last_sum = '0; last_cout = 1'b0; last_id = 1'b0;
      chk("rst_vld", resp_valid, 0);
      chk("rst_sum", resp_sum, 0);
      chk("rst_cout", resp_cout, 0);
      chk("rst_id", resp_id, 0);
      chk("rst_busy", busy, 0);
    end else if (!m_busy) begin
      g0 = req0_valid && (!req1_valid || !m_ptr);
      g1 = req1_valid && !g0;
      chk("idle_rdy0", req0_ready, g0);
      chk("idle_rdy1", req1_ready, g1);
      chk("idle_busy", busy, 0);
      chk("idle_vld", resp_valid, 0);
      chk("idle_sum_hold", resp_sum, last_sum);
      chk("idle_cout_hold", resp_cout, last_cout);
      chk("idle_id_hold", resp_id, last_id);
      if (g0 || g1) begin
        full = g1 ? ({1'b0, req1_a} + {1'b0, req1_b}) : ({1'b0, req0_a} + {1'b0, req0_b});
        e.id = g1; e.sum = full[WIDTH-1:0]; e.cout = full[WIDTH];
        sb.push_back(e);
        acc_cyc.push_back(cyc);
        m_busy = 1'b1;
        m_wait = WIDTH;
      end
    end else begin
      chk("run_busy", busy, 1);
      chk("run_rdy0", req0_ready, 0);
      chk("run_rdy1", req1_ready, 0);
      if (m_wait > 0) begin
        chk("shift_vld", resp_valid, 0);
        chk("shift_sum_hold", resp_sum, last_sum);
        m_wait--;
      end else begin
        chk("done_vld", resp_valid, 1);
        chk("sb_nonempty", sb.size(), 1);
        if (sb.size() > 0) begin
          e = sb[0];
          chk("done_id", resp_id, e.id);
          chk("done_sum", resp_sum, e.sum);
          chk("done_cout", resp_cout, e.cout);
          if (resp_ready) begin
            void'(sb.pop_front());
            last_sum = e.sum; last_cout = e.cout; last_id = e.id;
            m_ptr = !e.id;
            ids_seen.push_back(e.id);
            m_busy = 1'b0;
          end
        end
      end
    end
  end

  // Drains the operand queues; operands scramble after each accept.
  task automatic run_reqs(input int budget);
    int  n = 0;
    logic a0, a1;
    if (q0a.size() > 0) begin req0_a = q0a.pop_front(); req0_b = q0b.pop_front(); req0_valid = 1'b1; end
    if (q1a.size() > 0) begin req1_a = q1a.pop_front(); req1_b = q1b.pop_front(); req1_valid = 1'b1; end
    while ((req0_valid || req1_valid || m_busy) && n < budget) begin
      @(negedge clk);
      a0 = req0_valid && req0_ready;
      a1 = req1_valid && req1_ready;
      @(posedge clk);
      #1;
      if (a0) begin
        if (q0a.size() > 0) begin req0_a = q0a.pop_front(); req0_b = q0b.pop_front(); end
        else begin req0_valid = 1'b0; req0_a = WIDTH'($urandom); req0_b = WIDTH'($urandom); end
      end
      if (a1) begin
        if (q1a.size() > 0) begin req1_a = q1a.pop_front(); req1_b = q1b.pop_front(); end
        else begin req1_valid = 1'b0; req1_a = WIDTH'($urandom); req1_b = WIDTH'($urandom); end
      end
      n++;
    end
    chk("run_complete", {req0_valid, req1_valid, m_busy}, 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; resp_ready = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    q0a.push_back(8'h35); q0b.push_back(8'h1C);
    run_reqs(50);

    q1a.push_back(8'hFF); q1b.push_back(8'h01);
    q1a.push_back(8'hFF); q1b.push_back(8'hFF);
    run_reqs(60);

    do_reset();
    ids_seen.delete();
    q0a.push_back(8'd3);  q0b.push_back(8'd4);
    q1a.push_back(8'd10); q1b.push_back(8'd20);
    run_reqs(60);
    chk("tie_count", ids_seen.size(), 2);
    for (int i = 0; i < ids_seen.size(); i++) chk("tie_order", ids_seen[i], i % 2);

    acc_cyc.delete(); ids_seen.delete();
    for (int i = 0; i < 2; i++) begin
      q0a.push_back(WIDTH'($urandom)); q0b.push_back(WIDTH'($urandom));
      q1a.push_back(WIDTH'($urandom)); q1b.push_back(WIDTH'($urandom));
    end
    run_reqs(100);
    chk("rr_count", ids_seen.size(), 4);
    for (int i = 0; i < ids_seen.size(); i++) chk("rr_order", ids_seen[i], i % 2);
    for (int i = 1; i < acc_cyc.size(); i++) chk("rr_gap", acc_cyc[i] - acc_cyc[i-1], WIDTH + 2);

    resp_ready = 1'b0;
    q0a.push_back(8'hA5); q0b.push_back(8'h3C);
    q1a.push_back(8'h7F); q1b.push_back(8'h80);
    fork
      run_reqs(80);
      begin
        for (int i = 0; i < 40 && !resp_valid; i++) @(negedge clk);
        repeat (5) @(posedge clk);
        #1 resp_ready = 1'b1;
      end
    join

    q0a.push_back(WIDTH'($urandom)); q0b.push_back(WIDTH'($urandom));
    fork
      run_reqs(40);
      begin
        for (int i = 0; i < 20 && !m_busy; i++) begin @(negedge clk); #1; end
        repeat (4) @(posedge clk);
        #3 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
      end
    join
    q0a.push_back(8'h80); q0b.push_back(8'h80);
    run_reqs(50);
    chk("post_rst_sum", resp_sum, 8'h00);
    chk("post_rst_cout", resp_cout, 1);

    for (int i = 0; i < 4; i++) begin
      q0a.push_back(WIDTH'($urandom)); q0b.push_back(WIDTH'($urandom));
      q1a.push_back(WIDTH'($urandom)); q1b.push_back(WIDTH'($urandom));
    end
    run_reqs(200);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
